// File: rtl/dsk_dma_port_pkg.sv
// Shared constants for the disk-side DMA channel port.
package dsk_dma_port_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 13;

  typedef logic [CNT_W-1:0] cnt_t;

  // Channel sequencer states
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

endpackage

// File: rtl/dsk_dma_port_sync_fifo.sv
// Single-clock FIFO with AW+1 bit pointers and a combinational head.
module dsk_dma_port_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          cl,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  // Same slot, opposite wrap bit
  assign full  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign rdata = mem[rptr_q[AW-1:0]];

  always_ff @(posedge cl or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge cl) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dsk_dma_port.sv
// Disk-side DMA channel port: FIFO between disk engine and DMA controller,
// with request generation, strobe decode and byte-count termination.
module dsk_dma_port #(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned THRESH = 4
) (
  input  logic                                cl,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                dir,
  input  logic [dsk_dma_port_pkg::CNT_W-1:0]  count,
  input  logic                                src_valid,
  input  logic [DW-1:0]                       src_data,
  output logic                                src_ready,
  output logic                                snk_valid,
  output logic [DW-1:0]                       snk_data,
  input  logic                                snk_ready,
  output logic                                dreq,
  input  logic                                dack,
  input  logic                                ior_n,
  input  logic                                iow_n,
  input  logic [DW-1:0]                       dma_din,
  output logic [DW-1:0]                       dma_dout,
  output logic                                dma_doe,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);
  import dsk_dma_port_pkg::*;

  logic [1:0]    state_q, state_d;
  logic          dir_q, dir_d;
  cnt_t          rem_q, rem_d, fill_q, fill_d;
  logic          err_q, err_d, dreq_q, dreq_d, done_q, done_d;
  logic          dreq_cond;

  logic          f_clr, f_push, f_pop, f_full, f_empty;
  logic [DW-1:0] f_wdata, f_rdata, head;
  logic [AW:0]   f_level, free;

  logic          active, rd_strobe, wr_strobe, dma_rd, dma_wr, src_push, snk_pop;

  assign active = (state_q == StActive);
  assign free   = (AW+1)'(DEPTH) - f_level;

  // Strobes past the programmed count are ignored rather than underflowing rem
  assign rd_strobe = active & ~dir_q & dack & ~ior_n & (rem_q != '0);
  assign wr_strobe = active & dir_q & dack & ~iow_n & ior_n & (rem_q != '0);
  assign dma_rd    = rd_strobe & ~f_empty;
  assign dma_wr    = wr_strobe & ~f_full;

  assign src_ready = active & ~dir_q & ~f_full & (fill_q != '0);
  assign src_push  = src_valid & src_ready;
  assign snk_valid = active & dir_q & ~f_empty;
  assign snk_pop   = snk_valid & snk_ready;

  assign f_push  = src_push | dma_wr;
  assign f_pop   = dma_rd | snk_pop;
  assign f_wdata = dir_q ? dma_din : src_data;

  assign head     = f_empty ? '0 : f_rdata;
  assign snk_data = head;
  assign dma_dout = head;
  assign dma_doe  = active & ~dir_q & dack & ~ior_n;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;
  assign dreq     = dreq_q;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    fill_d    = fill_q;
    err_d     = err_q;
    done_d    = 1'b0;
    f_clr     = 1'b0;
    dreq_cond = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (count != '0) begin
            state_d = StActive;
            dir_d   = dir;
            rem_d   = count;
            fill_d  = count;
            f_clr   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StActive: begin
        if ((rem_q == '0) && (!dir_q || f_empty)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
        if (dma_rd | dma_wr) rem_d  = rem_q - cnt_t'(1);
        if (src_push)        fill_d = fill_q - cnt_t'(1);
        if ((rd_strobe & f_empty) | (wr_strobe & f_full)) err_d = 1'b1;
        if (dir_q) begin
          dreq_cond = (free >= (AW+1)'(THRESH)) ||
                      ((rem_q != '0) && (rem_q <= cnt_t'(free)));
        end else begin
          dreq_cond = (f_level >= (AW+1)'(THRESH)) || ((fill_q == '0) && !f_empty);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request drops in the same cycle the remaining count reaches zero
  assign dreq_d = active & dreq_cond & (rem_d != '0);

  always_ff @(posedge cl or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      dreq_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      dreq_q  <= dreq_d;
      done_q  <= done_d;
    end
  end

  dsk_dma_port_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_fifo (
    .cl    (cl),
    .rst   (rst),
    .clr   (f_clr),
    .push  (f_push),
    .wdata (f_wdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .level (f_level)
  );

endmodule
